// File: rtl/lane_masked_dual_port_ram.sv
// Simple dual-port RAM with per-lane write mask, write-first forwarding and a zero-sweep sequencer.
// Define SDP_RAM_OUT_REG_EN to add a second output register stage (read latency 2).
module lane_masked_dual_port_ram #(
  parameter int ADDR_WIDTH = 15,
  parameter int LANE_WIDTH = 7,
  parameter int NUM_LANES  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr_start,
  output logic                             clr_busy,
  input  logic                             wr_en,
  input  logic [NUM_LANES-1:0]             wr_lane_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [LANE_WIDTH*NUM_LANES-1:0]  data_i,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [LANE_WIDTH*NUM_LANES-1:0]  data_o_r,
  output logic                             rd_valid_o
);

  localparam int DATA_WIDTH = LANE_WIDTH * NUM_LANES;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    usr_we, clr_we, rd_accept;

  assign clr_busy  = (state_q == CLEAR);
  assign usr_we    = wr_en && (state_q == IDLE) && !rst;
  assign clr_we    = (state_q == CLEAR) && !rst;
  assign rd_accept = rd_en && (state_q == IDLE);

  // NOTE: next-state logic assigns its default first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clr_start) state_d = CLEAR;
      CLEAR:   if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && clr_start) clr_cnt <= '0;
      else if (state_q == CLEAR)         clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // NOTE: the array itself has no reset; only the sweep or host writes change its contents.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      ram[clr_cnt] <= '0;
    end else if (usr_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_lane_en[i]) ram[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= data_i[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Write-first: lanes written this cycle to the read address override the stored word.
  always_comb begin
    rd_word = ram[rd_addr];
    if (usr_we && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (wr_lane_en[i]) rd_word[i*LANE_WIDTH +: LANE_WIDTH] = data_i[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_data_q <= rd_word;
    end
  end

`ifdef SDP_RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;

  // Second stage only forwards completed reads, so it is unaffected by the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) out_data_q <= rd_data_q;
    end
  end

  assign data_o_r   = out_data_q;
  assign rd_valid_o = out_valid_q;
`else
  assign data_o_r   = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

endmodule
